// File: rtl/pipe_pkg.sv
// Shared pipeline types: hazard FSM states,
// the register-zero constant and the control bundle.
package pipe_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MUL_WAIT = 1'b1
  } hz_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_flush;
    logic id_ex_bubble;
  } ctrl_t;

  localparam ctrl_t CTRL_RESET = '{
    pc_write:     1'b0,
    if_id_write:  1'b0,
    if_flush:     1'b1,
    id_ex_bubble: 1'b1
  };

  localparam ctrl_t CTRL_STALL = '{
    pc_write:     1'b0,
    if_id_write:  1'b0,
    if_flush:     1'b0,
    id_ex_bubble: 1'b1
  };

  localparam ctrl_t CTRL_FLUSH = '{
    pc_write:     1'b1,
    if_id_write:  1'b1,
    if_flush:     1'b1,
    id_ex_bubble: 1'b0
  };

  localparam ctrl_t CTRL_RUN = '{
    pc_write:     1'b1,
    if_id_write:  1'b1,
    if_flush:     1'b0,
    id_ex_bubble: 1'b0
  };

endpackage

// File: rtl/hazard_cmp.sv
// Load-use comparator between the ID/EX load and the IF/ID sources.
// In: ex_mem_read, ex_rt, id_rs, id_rt, id_uses_rt. Out: load_use.
module hazard_cmp
  import pipe_pkg::*;
(
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rt,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  output logic       load_use
);

  logic rs_hit;
  logic rt_hit;

  assign rs_hit = (ex_rt == id_rs);
  assign rt_hit = id_uses_rt & (ex_rt == id_rt);

  // r0 is hardwired zero, so a load into it never creates a hazard
  assign load_use = ex_mem_read
                  & (ex_rt != REG_ZERO)
                  & (rs_hit | rt_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard control: load-use stall, multi-cycle mul/div hold,
// branch/jump flush. In: clk, reset, ID/EX hazard fields, redirects.
// Out: pc_write, if_id_write, if_flush, id_ex_bubble, stall_count.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MUL_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rt,
  input  logic        id_mul,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rt,
  input  logic        branch_taken,
  input  logic        jump,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        if_flush,
  output logic        id_ex_bubble,
  output logic [15:0] stall_count
);

  localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);

  hz_state_t  state;
  logic [3:0] mul_cnt;
  logic       mul_done;
  logic       load_use;
  logic       mul_start;
  logic       stall;
  logic       redirect;
  ctrl_t      ctrl;

  hazard_cmp u_cmp (
    .ex_mem_read (ex_mem_read),
    .ex_rt       (ex_rt),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rt  (id_uses_rt),
    .load_use    (load_use)
  );

  // mul_done masks id_mul for the single RUN cycle after a wait,
  // letting the finished multiply leave ID instead of restarting
  assign mul_start = (state == RUN) & ~load_use
                   & id_mul & ~mul_done;

  assign stall    = (state == MUL_WAIT) | load_use | mul_start;
  assign redirect = branch_taken | jump;

  always_comb begin
    ctrl = CTRL_RUN;
    if (reset) begin
      ctrl = CTRL_RESET;
    end else if (stall) begin
      ctrl = CTRL_STALL;
    end else if (redirect) begin
      ctrl = CTRL_FLUSH;
    end
  end

  assign pc_write     = ctrl.pc_write;
  assign if_id_write  = ctrl.if_id_write;
  assign if_flush     = ctrl.if_flush;
  assign id_ex_bubble = ctrl.id_ex_bubble;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      mul_cnt     <= 4'd0;
      mul_done    <= 1'b0;
      stall_count <= 16'd0;
    end else begin
      mul_done <= 1'b0;
      case (state)
        RUN: begin
          if (mul_start) begin
            state   <= MUL_WAIT;
            mul_cnt <= MUL_LOAD;
          end
        end
        MUL_WAIT: begin
          mul_cnt <= mul_cnt - 4'd1;
          if (mul_cnt == 4'd1) begin
            state    <= RUN;
            mul_done <= 1'b1;
          end
        end
        default: state <= RUN;
      endcase
      if (ctrl.id_ex_bubble && (stall_count != 16'hFFFF)) begin
        stall_count <= stall_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios
// plus random traffic against a cycle-level behavioural model.
module tb_pipe_hazard_ctrl;

  localparam int MULC = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_uses_rt;
  logic        id_mul;
  logic        ex_mem_read;
  logic [4:0]  ex_rt;
  logic        branch_taken;
  logic        jump;
  logic        pc_write;
  logic        if_id_write;
  logic        if_flush;
  logic        id_ex_bubble;
  logic [15:0] stall_count;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MUL_CYCLES(MULC)) dut (
    .clk          (clk),
    .reset        (reset),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rt   (id_uses_rt),
    .id_mul       (id_mul),
    .ex_mem_read  (ex_mem_read),
    .ex_rt        (ex_rt),
    .branch_taken (branch_taken),
    .jump         (jump),
    .pc_write     (pc_write),
    .if_id_write  (if_id_write),
    .if_flush     (if_flush),
    .id_ex_bubble (id_ex_bubble),
    .stall_count  (stall_count)
  );

  int errors = 0;
  int checks = 0;

  // model: remaining wait cycles, one-cycle mul mask, stall total
  int m_wait   = 0;
  bit m_ignore = 0;
  int m_cnt    = 0;

  logic e_pc, e_ifid, e_flush, e_bub;
  bit   e_start;

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic rst, input logic mr,
                        input logic [4:0] ert,
                        input logic [4:0] rs,
                        input logic [4:0] rt,
                        input logic urt, input logic mul,
                        input logic bt, input logic jp);
    reset        = rst;
    ex_mem_read  = mr;
    ex_rt        = ert;
    id_rs        = rs;
    id_rt        = rt;
    id_uses_rt   = urt;
    id_mul       = mul;
    branch_taken = bt;
    jump         = jp;
  endtask

  task automatic model_eval();
    bit lu;
    lu = ex_mem_read && (ex_rt != 0) &&
         ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    e_start = 0;
    if (reset) begin
      {e_pc, e_ifid, e_flush, e_bub} = 4'b0011;
    end else if (m_wait > 0 || lu) begin
      {e_pc, e_ifid, e_flush, e_bub} = 4'b0001;
    end else if (id_mul && !m_ignore) begin
      {e_pc, e_ifid, e_flush, e_bub} = 4'b0001;
      e_start = 1;
    end else if (branch_taken || jump) begin
      {e_pc, e_ifid, e_flush, e_bub} = 4'b1110;
    end else begin
      {e_pc, e_ifid, e_flush, e_bub} = 4'b1100;
    end
  endtask

  task automatic model_clock();
    if (reset) begin
      m_wait   = 0;
      m_ignore = 0;
      m_cnt    = 0;
    end else begin
      m_ignore = 0;
      if (m_wait > 0) begin
        m_wait--;
        if (m_wait == 0) m_ignore = 1;
      end else if (e_start) begin
        m_wait = MULC - 1;
      end
      if (e_bub && m_cnt < 65535) m_cnt++;
    end
  endtask

  // inputs are set at the falling edge; outputs sampled 1ns later
  task automatic step(input bit quiet = 0);
    #1;
    model_eval();
    if (!quiet) begin
      chk("pc_write",     16'(pc_write),     16'(e_pc));
      chk("if_id_write",  16'(if_id_write),  16'(e_ifid));
      chk("if_flush",     16'(if_flush),     16'(e_flush));
      chk("id_ex_bubble", 16'(id_ex_bubble), 16'(e_bub));
      chk("stall_count",  stall_count,       16'(m_cnt));
    end
    @(posedge clk);
    model_clock();
    @(negedge clk);
  endtask

  initial begin
    set_in(1, 1, 5'd7, 5'd7, 5'd3, 1, 1, 1, 1);
    @(negedge clk);
    step();
    set_in(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
    #1;
    chk("rst_flush", 16'(if_flush), 16'd1);
    chk("rst_bubble", 16'(id_ex_bubble), 16'd1);
    step();

    // load-use on rs
    set_in(0, 1, 5'd5, 5'd5, 5'd9, 0, 0, 0, 0);
    #1;
    chk("lu_pc", 16'(pc_write), 16'd0);
    chk("lu_bubble", 16'(id_ex_bubble), 16'd1);
    chk("lu_cnt0", stall_count, 16'd0);
    step();
    set_in(0, 0, 5'd0, 5'd1, 5'd2, 0, 0, 0, 0);
    #1;
    chk("lu_cnt1", stall_count, 16'd1);
    step();

    // load into r0 is not a hazard
    set_in(0, 1, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0);
    #1;
    chk("r0_pc", 16'(pc_write), 16'd1);
    step();

    // multiply: four stall cycles then release with id_mul held
    set_in(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
    step();
    set_in(0, 0, 5'd0, 5'd1, 5'd2, 0, 1, 0, 0);
    for (int i = 0; i < MULC; i++) begin
      #1;
      chk("mul_bubble", 16'(id_ex_bubble), 16'd1);
      step();
    end
    #1;
    chk("mul_release", 16'(pc_write), 16'd1);
    chk("mul_cnt", stall_count, 16'd4);
    step();
    set_in(0, 0, 5'd0, 5'd1, 5'd2, 0, 0, 0, 0);
    step();

    // load-use outranks a taken branch
    set_in(0, 1, 5'd4, 5'd1, 5'd4, 1, 0, 1, 0);
    #1;
    chk("pri_bubble", 16'(id_ex_bubble), 16'd1);
    chk("pri_flush", 16'(if_flush), 16'd0);
    step();
    set_in(0, 0, 5'd4, 5'd1, 5'd4, 1, 0, 1, 0);
    #1;
    chk("br_flush", 16'(if_flush), 16'd1);
    chk("br_pc", 16'(pc_write), 16'd1);
    step();

    // reset in the middle of a multiply wait
    set_in(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
    step();
    set_in(0, 0, 5'd0, 5'd1, 5'd2, 0, 1, 1, 0);
    step();
    step();
    set_in(1, 0, 5'd0, 5'd1, 5'd2, 0, 1, 0, 0);
    #1;
    chk("rmw_flush", 16'(if_flush), 16'd1);
    chk("rmw_bubble", 16'(id_ex_bubble), 16'd1);
    step();
    set_in(0, 0, 5'd0, 5'd1, 5'd2, 0, 0, 0, 0);
    #1;
    chk("rmw_pc", 16'(pc_write), 16'd1);
    chk("rmw_cnt", stall_count, 16'd0);
    step();

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      set_in($urandom_range(0, 39) == 0,
             $urandom_range(0, 2) == 0,
             5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)),
             $urandom_range(0, 1) == 1,
             $urandom_range(0, 5) == 0,
             $urandom_range(0, 3) == 0,
             $urandom_range(0, 5) == 0);
      step();
    end

    // saturation of the stall counter
    set_in(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
    step();
    set_in(0, 1, 5'd6, 5'd6, 5'd0, 0, 0, 0, 0);
    for (int i = 0; i < 70000; i++) step(1);
    step();
    chk("sat_cnt", stall_count, 16'hFFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter MUL_CYCLES, default 4: total ID-stage occupancy of a multi-cycle multiply/divide instruction, legal range 2..15.
REQ-002 Port clk  input  1  the single clock; all state updates on the rising edge.
REQ-003 Port reset  input  1  synchronous active-high reset, sampled on the clk rising edge.
REQ-004 Port id_rs  input  5  rs field of the instruction held in IF/ID.
REQ-005 Port id_rt  input  5  rt field of the instruction held in IF/ID.
REQ-006 Port id_uses_rt  input  1  ID instruction reads rt as a source.
REQ-007 Port id_mul  input  1  ID instruction is a multi-cycle multiply/divide.
REQ-008 Port ex_mem_read  input  1  instruction in ID/EX is a load.
REQ-009 Port ex_rt  input  5  destination register of the ID/EX load.
REQ-010 Port branch_taken  input  1  branch in ID resolved taken this cycle.
REQ-011 Port jump  input  1  jump in ID this cycle.
REQ-012 Port pc_write  output  1  PC register update enable.
REQ-013 Port if_id_write  output  1  IF/ID register write enable.
REQ-014 Port if_flush  output  1  IF/ID loads a zero instruction (NOP).
REQ-015 Port id_ex_bubble  output  1  ID/EX control fields forced to zero.
REQ-016 Port stall_count  output  16  saturating count of stall cycles since reset.

Function
REQ-017 State machine SHALL have states RUN and MUL_WAIT, plus a 4-bit down-counter mul_cnt.
REQ-018 load_use SHALL be ex_mem_read & (ex_rt != 0) & ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt))).
REQ-019 In RUN with load_use=1: pc_write=0, if_id_write=0, if_flush=0, id_ex_bubble=1, state stays RUN; all in the same cycle (combinational).
REQ-020 In RUN with load_use=0 and id_mul=1: outputs as REQ-019; next state MUL_WAIT, mul_cnt loaded with MUL_CYCLES-1.
REQ-021 In MUL_WAIT: pc_write=0, if_id_write=0, if_flush=0, id_ex_bubble=1; mul_cnt decrements each cycle; when mul_cnt==1, next state RUN.
REQ-022 id_mul SHALL be ignored for the first RUN cycle after MUL_WAIT exits (registered mul_done flag), so the same instruction does not re-enter MUL_WAIT.
REQ-023 In RUN with no stall and (branch_taken | jump)=1: pc_write=1, if_id_write=1, if_flush=1, id_ex_bubble=0.
REQ-024 In RUN with no stall and no redirect: pc_write=1, if_id_write=1, if_flush=0, id_ex_bubble=0.
REQ-025 Priority SHALL be load_use > id_mul > redirect. branch_taken and jump are ignored whenever a stall is asserted, including throughout MUL_WAIT.
REQ-026 stall_count SHALL increment by 1 in every cycle with id_ex_bubble=1 and saturate at 16'hFFFF.
REQ-027 Outputs SHALL never assert if_flush and id_ex_bubble together outside reset.

Reset
REQ-028 While reset=1: pc_write=0, if_id_write=0, if_flush=1, id_ex_bubble=1, independent of the other inputs.
REQ-029 On the clock edge with reset=1: state to RUN, mul_cnt to 0, mul_done to 0, stall_count to 0.
REQ-030 Reset asserted during MUL_WAIT SHALL abort the wait; the first cycle after reset deasserts follows RUN rules.

Structure
REQ-031 The state encoding (RUN, MUL_WAIT) and the register-zero constant SHALL live in the shared pipeline package (pipe_pkg).
REQ-032 The load-use comparator SHALL be a separate combinational sub-module, hazard_cmp, with outputs load_use only.
REQ-033 Outputs SHALL be combinational from the registered state plus current inputs. No output register is permitted, so stall and flush act in the detecting cycle.

Verification
REQ-034 Load-use: ex_mem_read=1, ex_rt=5, id_rs=5 for one cycle -> pc_write=0, if_id_write=0, id_ex_bubble=1 that cycle; stall_count 0->1.
REQ-035 Load to r0: ex_mem_read=1, ex_rt=0, id_rs=0 -> no stall, pc_write=1.
REQ-036 Multiply: id_mul=1 held with MUL_CYCLES=4 -> stall outputs for exactly 4 consecutive cycles, then pc_write=1 with id_mul still 1; stall_count=4.
REQ-037 Priority: load_use=1 and branch_taken=1 in the same cycle -> id_ex_bubble=1, if_flush=0; next cycle with load_use=0 and branch_taken=1 -> if_flush=1, pc_write=1.
REQ-038 Reset mid-wait: reset=1 on the 2nd MUL_WAIT cycle -> if_flush=1 and id_ex_bubble=1 during reset; the cycle after, with id_mul=0, gives pc_write=1 and stall_count=0.
REQ-039 Saturation: force 70000 stall cycles -> stall_count holds 16'hFFFF.
